// File: rtl/write_back_stage_if.sv
// Execute-to-write-back bus: retiring instruction, load response, register-file write,
// hazard and fault status. The stage uses the slave modport; its driver uses master.
interface write_back_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = $clog2(XLEN / 8)
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_write_enable;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [1:0]            in_sel;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_pc;
    logic [2:0]            in_load_funct3;
    logic [OFF_W-1:0]      in_load_off;
    logic                  mem_rsp_valid;
    logic [XLEN-1:0]       mem_rsp_data;
    logic                  mem_rsp_error;
    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_addr_rd;
    logic [XLEN-1:0]       rf_write_data;
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic                  load_fault;
    logic [63:0]           instret;

    modport master (
        output in_valid, in_write_enable, in_rd, in_sel, in_alu_result, in_pc,
               in_load_funct3, in_load_off, mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        input  in_ready, rf_write_enable, rf_addr_rd, rf_write_data, pend_valid, pend_rd,
               load_fault, instret
    );

    modport slave (
        input  in_valid, in_write_enable, in_rd, in_sel, in_alu_result, in_pc,
               in_load_funct3, in_load_off, mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        output in_ready, rf_write_enable, rf_addr_rd, rf_write_data, pend_valid, pend_rd,
               load_fault, instret
    );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: retires ALU / PC+4 results in one cycle, waits for and extends load data.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module write_back_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = $clog2(XLEN / 8)
) (
    input logic               clk,
    input logic               reset_n,
    write_back_stage_if.slave bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC  = 2'd2;
    localparam logic [1:0] SEL_RSV = 2'd3;

    state_e                state_q;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_addr_q;
    logic [XLEN-1:0]       rf_data_q;
    logic                  ld_we_q;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic [2:0]            ld_f3_q;
    logic [OFF_W-1:0]      ld_off_q;
    logic                  load_fault_q;

    logic                  accept;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       load_data_d;
    logic                  load_bad_d;
    logic [XLEN-1:0]       exec_data_d;

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign exec_data_d  = (bus.in_sel == SEL_PC) ? bus.in_pc + XLEN'(4) : bus.in_alu_result;

    // Aligned accesses always start at byte offset*8, so one shift serves every lane size.
    assign shifted = bus.mem_rsp_data >> {ld_off_q, 3'b000};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        load_data_d = shifted;
        load_bad_d  = 1'b0;
        case (ld_f3_q)
            3'b000: load_data_d = XLEN'($signed(shifted[7:0]));
            3'b001: begin
                load_data_d = XLEN'($signed(shifted[15:0]));
                load_bad_d  = ld_off_q[0];
            end
            3'b010: begin
                load_data_d = XLEN'($signed(shifted[31:0]));
                load_bad_d  = |ld_off_q[1:0];
            end
            3'b100: load_data_d = XLEN'(shifted[7:0]);
            3'b101: begin
                load_data_d = XLEN'(shifted[15:0]);
                load_bad_d  = ld_off_q[0];
            end
            3'b011: load_bad_d = (XLEN != 64) || (ld_off_q != '0);
            3'b110: begin
                load_data_d = XLEN'(shifted[31:0]);
                load_bad_d  = (XLEN != 64) || (|ld_off_q[1:0]);
            end
            default: load_bad_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; strobes default low each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            ld_we_q      <= 1'b0;
            ld_rd_q      <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            load_fault_q <= 1'b0;
        end else begin
            rf_we_q      <= 1'b0;
            load_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_sel == SEL_MEM) begin
                            state_q  <= WAIT_MEM;
                            ld_we_q  <= bus.in_write_enable;
                            ld_rd_q  <= bus.in_rd;
                            ld_f3_q  <= bus.in_load_funct3;
                            ld_off_q <= bus.in_load_off;
                        end else if (bus.in_write_enable && (bus.in_rd != '0) &&
                                     (bus.in_sel != SEL_RSV)) begin
                            rf_we_q   <= 1'b1;
                            rf_addr_q <= bus.in_rd;
                            rf_data_q <= exec_data_d;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rsp_valid) begin
                        state_q <= IDLE;
                        if (load_bad_d || bus.mem_rsp_error) begin
                            load_fault_q <= 1'b1;
                        end else if (ld_we_q && (ld_rd_q != '0)) begin
                            rf_we_q   <= 1'b1;
                            rf_addr_q <= ld_rd_q;
                            rf_data_q <= load_data_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_addr_rd      = rf_addr_q;
    assign bus.rf_write_data   = rf_data_q;
    assign bus.pend_valid      = (state_q == WAIT_MEM);
    assign bus.pend_rd         = ld_rd_q;
    assign bus.load_fault      = load_fault_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;
    logic        retire;

    // Reserved selects and writes to x0 still retire; only abandoned loads are not counted.
    assign retire = (accept && (bus.in_sel != SEL_MEM)) ||
                    ((state_q == WAIT_MEM) && bus.mem_rsp_valid && !load_bad_d && !bus.mem_rsp_error);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed steps then random traffic against a
// transaction-level reference model of retirement and load extraction.
`timescale 1ns/1ps
module tb_write_back_stage;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int OFF_W      = $clog2(XLEN / 8);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    write_back_stage_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .OFF_W(OFF_W)) bus ();

    write_back_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .OFF_W(OFF_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding load, expected write-port contents, retired count.
    bit                    m_busy;
    bit                    m_we;
    logic [REG_ADDR_W-1:0] m_rd;
    logic [2:0]            m_f3;
    int                    m_off;
    logic                  exp_we;
    logic [REG_ADDR_W-1:0] exp_addr;
    logic [XLEN-1:0]       exp_data;
    logic                  exp_fault;
    logic [63:0]           m_retired;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_load(input logic [2:0] f3, input int off, input logic [XLEN-1:0] w,
                                     output logic [XLEN-1:0] v, output bit bad);
        int          size;
        bit          sgn;
        logic [63:0] raw;
        logic [63:0] mask;
        bad  = 0;
        size = 1;
        sgn  = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = (XLEN == 64); end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            3'd3: begin size = 8; bad = (XLEN != 64); end
            3'd6: begin size = 4; bad = (XLEN != 64); end
            default: bad = 1;
        endcase
        if (off % size != 0) bad = 1;
        raw  = 64'(w) >> (8 * off);
        mask = (size == 8) ? '1 : (64'd1 << (8 * size)) - 64'd1;
        raw  = raw & mask;
        if (sgn && raw[8*size-1]) raw = raw | ~mask;
        v = raw[XLEN-1:0];
    endfunction

    task automatic model_reset();
        m_busy    = 0;
        m_we      = 0;
        m_rd      = '0;
        m_f3      = '0;
        m_off     = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_fault = 1'b0;
        m_retired = '0;
    endtask

    task automatic compare_all();
        check("in_ready", 64'(bus.in_ready), 64'(!m_busy));
        check("rf_we", 64'(bus.rf_write_enable), 64'(exp_we));
        check("rf_addr", 64'(bus.rf_addr_rd), 64'(exp_addr));
        check("rf_data", 64'(bus.rf_write_data), 64'(exp_data));
        check("pend_valid", 64'(bus.pend_valid), 64'(m_busy));
        if (m_busy) check("pend_rd", 64'(bus.pend_rd), 64'(m_rd));
        check("load_fault", 64'(bus.load_fault), 64'(exp_fault));
`ifdef WB_INSTRET_EN
        check("instret", bus.instret, m_retired);
`else
        check("instret", bus.instret, 64'd0);
`endif
    endtask

    // Apply the current inputs for one clock, advance the model, then compare after the edge.
    task automatic cycle();
        logic [XLEN-1:0] v;
        bit              bad;
        exp_we    = 1'b0;
        exp_fault = 1'b0;
        if (m_busy) begin
            if (bus.mem_rsp_valid) begin
                m_busy = 0;
                ref_load(m_f3, m_off, bus.mem_rsp_data, v, bad);
                if (bad || bus.mem_rsp_error) begin
                    exp_fault = 1'b1;
                end else begin
                    m_retired++;
                    if (m_we && m_rd != 0) begin
                        exp_we   = 1'b1;
                        exp_addr = m_rd;
                        exp_data = v;
                    end
                end
            end
        end else if (bus.in_valid) begin
            if (bus.in_sel == 2'd1) begin
                m_busy = 1;
                m_we   = bus.in_write_enable;
                m_rd   = bus.in_rd;
                m_f3   = bus.in_load_funct3;
                m_off  = int'(bus.in_load_off);
            end else begin
                m_retired++;
                if (bus.in_write_enable && bus.in_rd != 0 && bus.in_sel != 2'd3) begin
                    exp_we   = 1'b1;
                    exp_addr = bus.in_rd;
                    exp_data = (bus.in_sel == 2'd2) ? bus.in_pc + XLEN'(4) : bus.in_alu_result;
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        bus.in_valid        = 1'b0;
        bus.in_write_enable = 1'b0;
        bus.in_rd           = '0;
        bus.in_sel          = 2'd0;
        bus.in_alu_result   = '0;
        bus.in_pc           = '0;
        bus.in_load_funct3  = 3'd0;
        bus.in_load_off     = '0;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = '0;
        bus.mem_rsp_error   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [REG_ADDR_W-1:0] rd,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                         input logic [2:0] f3, input logic [OFF_W-1:0] off);
        bus.in_valid        = 1'b1;
        bus.in_write_enable = 1'b1;
        bus.in_sel          = sel;
        bus.in_rd           = rd;
        bus.in_alu_result   = alu;
        bus.in_pc           = pc;
        bus.in_load_funct3  = f3;
        bus.in_load_off     = off;
    endtask

    task automatic respond(input logic [XLEN-1:0] data, input logic err);
        bus.in_valid      = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        bus.mem_rsp_error = err;
    endtask

    initial begin
        set_idle();
        model_reset();
        #12;
        reset_n = 1'b1;
        compare_all();

        // ALU retire, then back-to-back PC+4 that wraps to zero.
        issue(2'd0, 5'd5, 32'hDEADBEEF, '0, 3'd0, '0);
        cycle();
        check("alu_strobe", 64'(bus.rf_write_enable), 64'd1);
        check("alu_data", 64'(bus.rf_write_data), 64'hDEADBEEF);
        issue(2'd2, 5'd6, '0, 32'hFFFFFFFC, 3'd0, '0);
        cycle();
        check("pc_wrap", 64'(bus.rf_write_data), 64'd0);

        // LB off 2 with a response offered during the accept cycle (ignored) and 3 wait cycles.
        issue(2'd1, 5'd7, '0, '0, 3'd0, 2'd2);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h11111111;
        cycle();
        bus.mem_rsp_valid = 1'b0;
        issue(2'd0, 5'd9, 32'h55, '0, 3'd0, '0);
        for (int i = 0; i < 3; i++) cycle();
        check("lb_wait_ready", 64'(bus.in_ready), 64'd0);
        check("lb_wait_pend_rd", 64'(bus.pend_rd), 64'd7);
        respond(32'h12803456, 1'b0);
        cycle();
        check("lb_data", 64'(bus.rf_write_data), 64'hFFFFFF80);
        set_idle();

        // LHU off 2 zero-extends; LH off 1 is misaligned.
        issue(2'd1, 5'd8, '0, '0, 3'd5, 2'd2);
        cycle();
        respond(32'h80010000, 1'b0);
        cycle();
        check("lhu_data", 64'(bus.rf_write_data), 64'h00008001);
        issue(2'd1, 5'd10, '0, '0, 3'd1, 2'd1);
        cycle();
        respond(32'hFFFFFFFF, 1'b0);
        cycle();
        check("lh_misalign_fault", 64'(bus.load_fault), 64'd1);
        set_idle();
        cycle();

        // Write to x0 is suppressed; bus error abandons an LW.
        issue(2'd0, 5'd0, 32'h1234, '0, 3'd0, '0);
        cycle();
        check("x0_no_strobe", 64'(bus.rf_write_enable), 64'd0);
        issue(2'd1, 5'd11, '0, '0, 3'd2, 2'd0);
        cycle();
        respond(32'hCAFEF00D, 1'b1);
        cycle();
        check("lw_err_fault", 64'(bus.load_fault), 64'd1);
        set_idle();
        bus.mem_rsp_valid = 1'b1;
        cycle();

        // Reset during WAIT_MEM, then a stale response after release.
        issue(2'd1, 5'd12, '0, '0, 3'd2, 2'd0);
        cycle();
        set_idle();
        cycle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        respond(32'h0BADBEEF, 1'b0);
        cycle();
        check("post_reset_ready", 64'(bus.in_ready), 64'd1);
        set_idle();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bus.in_valid        = ($urandom_range(0, 3) != 0);
            bus.in_write_enable = ($urandom_range(0, 7) != 0);
            bus.in_rd           = ($urandom_range(0, 5) == 0) ? '0 : REG_ADDR_W'($urandom);
            bus.in_sel          = 2'($urandom);
            bus.in_alu_result   = XLEN'($urandom);
            bus.in_pc           = ($urandom_range(0, 7) == 0) ? '1 : XLEN'($urandom);
            bus.in_load_funct3  = 3'($urandom);
            bus.in_load_off     = OFF_W'($urandom);
            bus.mem_rsp_valid   = ($urandom_range(0, 2) == 0);
            bus.mem_rsp_data    = XLEN'($urandom);
            bus.mem_rsp_error   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Registered, parametrised write-back stage that retires one instruction at a time from execute into the register file.
- Selects the write data from three sources: ALU result, PC+4, or load data.
- For loads, waits a variable number of cycles for the memory response, then extracts and sign- or zero-extends the loaded value.
- Exposes the pending load destination so issue logic can stall on hazards.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
REG_ADDR_W, 5, register-file address width.
OFF_W, $clog2(XLEN/8), byte-offset width within a memory word.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  retiring instruction valid.
in_ready  out  1  stage can accept an instruction.
in_write_enable  in  1  instruction writes rd.
in_rd  in  REG_ADDR_W  destination register.
in_sel  in  2  source select: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = reserved (no write).
in_alu_result  in  XLEN  ALU result.
in_pc  in  XLEN  instruction PC.
in_load_funct3  in  3  load type.
in_load_off  in  OFF_W  byte address offset of the load.
mem_rsp_valid  in  1  load data valid.
mem_rsp_data  in  XLEN  aligned memory word.
mem_rsp_error  in  1  bus error; qualified by mem_rsp_valid.
rf_write_enable  out  1  register-file write strobe.
rf_addr_rd  out  REG_ADDR_W  write address.
rf_write_data  out  XLEN  write data.
pend_valid  out  1  a load is outstanding.
pend_rd  out  REG_ADDR_W  rd of the outstanding load.
load_fault  out  1  one-cycle pulse when a load is abandoned.
instret  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on reset_n.
- Reset values: state = IDLE; rf_write_enable = 0; rf_addr_rd = 0; rf_write_data = 0; pend_valid = 0; pend_rd = 0; load_fault = 0; instret = 0.
- States: IDLE and WAIT_MEM.
- in_ready = (state == IDLE). It is combinational from state only, never from in_valid.
- Accept condition: in_valid && in_ready.
- IDLE, accept with sel ALU or PC:
  - Next cycle: rf_write_enable = in_write_enable && (in_rd != 0) && (sel != 3).
  - rf_addr_rd = in_rd.
  - rf_write_data = in_alu_result for ALU, or in_pc + 4 (mod 2^XLEN) for PC.
  - Latency is 1 cycle; back-to-back accepts are allowed every cycle.
- IDLE, accept with sel MEM:
  - Latch rd, write_enable, funct3 and offset; go to WAIT_MEM.
  - rf_write_enable = 0 next cycle.
  - pend_valid = 1 and pend_rd = latched rd, from the next cycle until the response is consumed.
- WAIT_MEM, mem_rsp_valid = 1:
  - Consume the response and return to IDLE.
  - Next cycle: write the extracted data, subject to write_enable && rd != 0. pend_valid clears that same next cycle.
  - A new instruction can be accepted the cycle after the response.
- Load extraction, using byte lane = off, half lane = off[OFF_W-1:1], word lane = off[OFF_W-1:2]:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW: sign-extend when XLEN = 64; pass-through when XLEN = 32.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - XLEN = 64 only: 011 LD and 110 LWU (zero-extend).
- Fault conditions: any other funct3, a misaligned access (LH/LHU with off[0] = 1; LW/LWU with off[1:0] != 0; LD with off != 0), or mem_rsp_error = 1.
  - On a fault: no write, load_fault = 1 for one cycle, return to IDLE.
- mem_rsp_valid in IDLE is ignored. No write and no fault result.
- mem_rsp_valid in the same cycle as a MEM accept is ignored. The response is only sampled in WAIT_MEM.
- Reset asserted mid-load: abandon WAIT_MEM immediately. A response arriving after reset is released is ignored.
- rf_write_enable is a single-cycle strobe. rf_addr_rd and rf_write_data hold their last values when the strobe is 0.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined: instret is a 64-bit counter. It increments by 1 on the cycle each instruction completes (the write-strobe cycle, including rd = 0 or write_enable = 0). Faulted loads are not counted. It wraps at 2^64 and resets to 0.
- Undefined: instret is tied to 0 and no counter is synthesised.

Test Plan:
- ALU retire: accept sel = 0, rd = 5, alu = 0xDEADBEEF -> next cycle rf_write_enable = 1, rf_addr_rd = 5, rf_write_data = 0xDEADBEEF. Then a back-to-back PC retire with pc = 0xFFFFFFFC -> rf_write_data = 0x00000000.
- Load with 3-cycle wait: LB, off = 2, rd = 7, response data 0x12_80_34_56 -> in_ready = 0 and pend_valid = 1, pend_rd = 7 during the wait; write 0xFFFFFF80 the cycle after the response.
- Extension and alignment: LHU off = 2 with data 0x8001_0000 -> writes 0x00008001. LH off = 1 -> load_fault pulse and no write.
- rd = 0 and bus error: ALU retire to x0 -> no write strobe. LW with mem_rsp_error = 1 -> load_fault = 1 and no write.
- Reset during WAIT_MEM: drop reset_n mid-wait, release, then pulse mem_rsp_valid -> no write, pend_valid = 0, in_ready = 1.
- With WB_INSTRET_EN: 3 ALU retires plus 1 faulted load -> instret = 3. Without the macro, instret = 0 throughout.
